// File: rtl/lcd_bus_arbiter.sv
// Owner of the shared HD44780 character LCD bus: runs the power-up init sequence, then
// serialises client byte writes under round-robin arbitration with per-client locking.
module lcd_bus_arbiter #(
    parameter int unsigned NREQ           = 3,
    parameter int unsigned SETUP_CYC      = 5,
    parameter int unsigned EN_CYC         = 25,
    parameter int unsigned WAIT_SHORT_CYC = 2500,
    parameter int unsigned WAIT_LONG_CYC  = 100000,
    parameter int unsigned PWRUP_CYC      = 2500000,
    parameter int unsigned LOCK_TO_CYC    = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_rs,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   grant,
    output logic              ready,
    output logic              lcd_rs,
    output logic              lcd_rw,
    output logic              lcd_en,
    output logic [7:0]        lcd_data
);

    localparam int unsigned IdxW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned MaxA   = (PWRUP_CYC > WAIT_LONG_CYC) ? PWRUP_CYC : WAIT_LONG_CYC;
    localparam int unsigned MaxB   = (WAIT_SHORT_CYC > EN_CYC) ? WAIT_SHORT_CYC : EN_CYC;
    localparam int unsigned MaxC   = (MaxB > SETUP_CYC) ? MaxB : SETUP_CYC;
    localparam int unsigned MaxCyc = (MaxA > MaxC) ? MaxA : MaxC;
    localparam int unsigned CntW   = $clog2(MaxCyc + 1);
    localparam int unsigned ToW    = $clog2(LOCK_TO_CYC + 1);

    localparam logic [CntW-1:0] PwrupLast     = CntW'(PWRUP_CYC - 1);
    localparam logic [CntW-1:0] SetupLast     = CntW'(SETUP_CYC - 1);
    localparam logic [CntW-1:0] EnLast        = CntW'(EN_CYC - 1);
    localparam logic [CntW-1:0] WaitShortLast = CntW'(WAIT_SHORT_CYC - 1);
    localparam logic [CntW-1:0] WaitLongLast  = CntW'(WAIT_LONG_CYC - 1);
    localparam logic [ToW-1:0]  LockToLast    = ToW'(LOCK_TO_CYC - 1);
    localparam logic [IdxW-1:0] LastIdx       = IdxW'(NREQ - 1);

    typedef enum logic [2:0] {
        StPwrup, StInitSetup, StInitPulse, StInitWait, StIdle, StSetup, StPulse, StWait
    } state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [1:0]        init_idx_q;
    logic              lock_vld_q;
    logic [IdxW-1:0]   lock_idx_q;
    logic [ToW-1:0]    lock_cnt_q;
    logic [IdxW-1:0]   last_grant_q;
    logic [NREQ-1:0]   ack_q;
    logic [NREQ-1:0]   grant_q;
    logic              ready_q;
    logic              lcd_rs_q;
    logic              lcd_en_q;
    logic [7:0]        lcd_data_q;

    logic              win_vld;
    logic [IdxW-1:0]   win_idx;
    logic [NREQ-1:0]   win_oh;
    logic [31:0]       cand;
    logic              wait_long;
    logic [CntW-1:0]   wait_last;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    init_cmd = 8'h38;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h06;
            default: init_cmd = 8'h01;
        endcase
    endfunction

    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        if (lock_vld_q) begin
            win_vld = req[lock_idx_q];
            win_idx = lock_idx_q;
        end else begin
            // Scan downwards so the candidate nearest after last_grant is written last and wins.
            for (int k = int'(NREQ); k >= 1; k--) begin
                cand = (32'(last_grant_q) + unsigned'(k)) % NREQ;
                if (req[cand[IdxW-1:0]]) begin
                    win_vld = 1'b1;
                    win_idx = cand[IdxW-1:0];
                end
            end
        end
    end

    always_comb begin
        win_oh          = '0;
        win_oh[win_idx] = 1'b1;
    end

    // Clear display / return home need the long settle time.
    assign wait_long = !lcd_rs_q && (lcd_data_q[7:2] == 6'd0) && (lcd_data_q[1:0] != 2'd0);
    assign wait_last = wait_long ? WaitLongLast : WaitShortLast;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StPwrup;
            cnt_q        <= '0;
            init_idx_q   <= '0;
            lock_vld_q   <= 1'b0;
            lock_idx_q   <= '0;
            lock_cnt_q   <= '0;
            last_grant_q <= LastIdx;
            ack_q        <= '0;
            grant_q      <= '0;
            ready_q      <= 1'b0;
            lcd_rs_q     <= 1'b0;
            lcd_en_q     <= 1'b0;
            lcd_data_q   <= '0;
        end else begin
            ack_q <= '0;
            cnt_q <= cnt_q + 1'b1;
            unique case (state_q)
                StPwrup: begin
                    if (cnt_q == PwrupLast) begin
                        cnt_q      <= '0;
                        init_idx_q <= '0;
                        lcd_rs_q   <= 1'b0;
                        lcd_data_q <= init_cmd(2'd0);
                        state_q    <= StInitSetup;
                    end
                end
                StInitSetup, StSetup: begin
                    if (cnt_q == SetupLast) begin
                        cnt_q    <= '0;
                        lcd_en_q <= 1'b1;
                        state_q  <= (state_q == StSetup) ? StPulse : StInitPulse;
                    end
                end
                StInitPulse, StPulse: begin
                    if (cnt_q == EnLast) begin
                        cnt_q    <= '0;
                        lcd_en_q <= 1'b0;
                        state_q  <= (state_q == StPulse) ? StWait : StInitWait;
                    end
                end
                StInitWait: begin
                    if (cnt_q == wait_last) begin
                        cnt_q <= '0;
                        if (init_idx_q == 2'd3) begin
                            ready_q <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            init_idx_q <= init_idx_q + 2'd1;
                            lcd_data_q <= init_cmd(init_idx_q + 2'd1);
                            state_q    <= StInitSetup;
                        end
                    end
                end
                StWait: begin
                    if (cnt_q == wait_last) begin
                        cnt_q   <= '0;
                        state_q <= StIdle;
                    end
                end
                StIdle: begin
                    cnt_q <= '0;
                    if (win_vld) begin
                        ack_q        <= win_oh;
                        lcd_rs_q     <= req_rs[win_idx];
                        lcd_data_q   <= req_data[8*win_idx +: 8];
                        last_grant_q <= win_idx;
                        lock_cnt_q   <= '0;
                        state_q      <= StSetup;
                        if (req_last[win_idx]) begin
                            lock_vld_q <= 1'b0;
                            grant_q    <= '0;
                        end else begin
                            lock_vld_q <= 1'b1;
                            lock_idx_q <= win_idx;
                            grant_q    <= win_oh;
                        end
                    end else if (lock_vld_q) begin
                        // Owner went quiet mid-transaction; release after the timeout.
                        if (lock_cnt_q == LockToLast) begin
                            lock_vld_q <= 1'b0;
                            grant_q    <= '0;
                            lock_cnt_q <= '0;
                        end else begin
                            lock_cnt_q <= lock_cnt_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign ack      = ack_q;
    assign grant    = grant_q;
    assign ready    = ready_q;
    assign lcd_rs   = lcd_rs_q;
    assign lcd_rw   = 1'b0;
    assign lcd_en   = lcd_en_q;
    assign lcd_data = lcd_data_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed bench for lcd_bus_arbiter: init timing, table of client bytes, locking,
// lock timeout and mid-operation reset, with small timing parameters.
module tb_lcd_bus_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic [2:0]  req_rs;
    logic [23:0] req_data;
    logic [2:0]  req_last;
    logic [2:0]  ack;
    logic [2:0]  grant;
    logic        ready;
    logic        lcd_rs;
    logic        lcd_rw;
    logic        lcd_en;
    logic [7:0]  lcd_data;

    int n_cmp = 0;
    int n_err = 0;

    lcd_bus_arbiter #(
        .NREQ          (3),
        .SETUP_CYC     (2),
        .EN_CYC        (3),
        .WAIT_SHORT_CYC(4),
        .WAIT_LONG_CYC (10),
        .PWRUP_CYC     (20),
        .LOCK_TO_CYC   (50)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .req_rs  (req_rs),
        .req_data(req_data),
        .req_last(req_last),
        .ack     (ack),
        .grant   (grant),
        .ready   (ready),
        .lcd_rs  (lcd_rs),
        .lcd_rw  (lcd_rw),
        .lcd_en  (lcd_en),
        .lcd_data(lcd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct packed {
        logic [1:0] client;
        logic       rs;
        logic [7:0] data;
        logic       last;
        logic [2:0] grant;
        logic [4:0] wt;
    } vec_t;

    vec_t vec [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_client(input int c, input logic on, input logic rs, input logic [7:0] d,
                              input logic last);
        req[c]             = on;
        req_rs[c]          = rs;
        req_data[8*c +: 8] = d;
        req_last[c]        = last;
    endtask

    // Starts on the first power-up cycle; follows the whole init sequence up to ready.
    task automatic check_init();
        logic [7:0] init_b [4];
        int lo;
        int hi;
        int acks;
        init_b[0] = 8'h38;
        init_b[1] = 8'h0C;
        init_b[2] = 8'h06;
        init_b[3] = 8'h01;
        acks = 0;
        for (int b = 0; b < 4; b++) begin
            lo = 0;
            while (!lcd_en && lo < 100) begin
                lo++;
                if (ack != 3'b000) acks++;
                @(negedge clk);
            end
            chk("init_low_cycles", lo, (b == 0) ? 22 : 6);
            chk("init_data", 32'(lcd_data), 32'(init_b[b]));
            chk("init_rs", 32'(lcd_rs), 0);
            chk("init_ready_low", 32'(ready), 0);
            hi = 0;
            while (lcd_en && hi < 100) begin
                hi++;
                @(negedge clk);
            end
            chk("init_en_high", hi, 3);
        end
        lo = 0;
        while (!ready && lo < 100) begin
            lo++;
            if (ack != 3'b000) acks++;
            @(negedge clk);
        end
        chk("init_final_wait", lo, 10);
        chk("init_no_ack", acks, 0);
        req = '0;
    endtask

    initial begin
        int n;
        int g0;
        int setup;
        int hi;
        int gap;
        int nack;
        int cyc;
        int p0;
        int p2;
        logic [2:0] exp_ack;
        logic [7:0] b0 [3];
        logic [7:0] b2 [3];
        int         ord_c [6];
        logic [2:0] ord_g [6];
        logic [7:0] ord_d [6];

        vec[0] = '{2'd1, 1'b1, 8'h35, 1'b1, 3'b000, 5'd4};
        vec[1] = '{2'd2, 1'b0, 8'h01, 1'b1, 3'b000, 5'd10};
        vec[2] = '{2'd2, 1'b0, 8'h80, 1'b1, 3'b000, 5'd4};
        vec[3] = '{2'd2, 1'b1, 8'h01, 1'b1, 3'b000, 5'd4};
        vec[4] = '{2'd2, 1'b0, 8'h02, 1'b0, 3'b100, 5'd10};
        vec[5] = '{2'd2, 1'b1, 8'h41, 1'b1, 3'b000, 5'd4};
        vec[6] = '{2'd0, 1'b0, 8'h04, 1'b1, 3'b000, 5'd4};
        vec[7] = '{2'd1, 1'b1, 8'hFF, 1'b1, 3'b000, 5'd4};
        vec[8] = '{2'd2, 1'b1, 8'h20, 1'b1, 3'b000, 5'd4};

        b0[0] = 8'hA0; b0[1] = 8'hA1; b0[2] = 8'hA2;
        b2[0] = 8'hC0; b2[1] = 8'hC1; b2[2] = 8'hC2;
        ord_c = '{0, 0, 0, 2, 2, 2};
        ord_g = '{3'b001, 3'b001, 3'b000, 3'b100, 3'b100, 3'b000};
        ord_d = '{8'hA0, 8'hA1, 8'hA2, 8'hC0, 8'hC1, 8'hC2};

        rst      = 1'b1;
        req      = '0;
        req_rs   = '0;
        req_data = '0;
        req_last = '0;
        repeat (3) @(negedge clk);
        chk("rst_en", 32'(lcd_en), 0);
        chk("rst_rs", 32'(lcd_rs), 0);
        chk("rst_rw", 32'(lcd_rw), 0);
        chk("rst_data", 32'(lcd_data), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_ready", 32'(ready), 0);
        rst = 1'b0;
        check_init();

        // Back-to-back client bytes; each gap measures the previous byte's wait.
        set_client(int'(vec[0].client), 1'b1, vec[0].rs, vec[0].data, vec[0].last);
        for (int j = 0; j < 9; j++) begin
            gap = 0;
            while (ack == 3'b000 && gap < 200) begin
                gap++;
                @(negedge clk);
            end
            if (j > 0) chk("vec_gap", gap, 32'(vec[j-1].wt) + 1);
            exp_ack = '0;
            exp_ack[vec[j].client] = 1'b1;
            chk("vec_ack", 32'(ack), 32'(exp_ack));
            chk("vec_grant", 32'(grant), 32'(vec[j].grant));
            chk("vec_data", 32'(lcd_data), 32'(vec[j].data));
            chk("vec_rs", 32'(lcd_rs), 32'(vec[j].rs));
            chk("vec_rw", 32'(lcd_rw), 0);
            req = '0;
            if (j < 8)
                set_client(int'(vec[j+1].client), 1'b1, vec[j+1].rs, vec[j+1].data,
                           vec[j+1].last);
            setup = 0;
            while (!lcd_en && setup < 100) begin
                setup++;
                @(negedge clk);
            end
            chk("vec_setup", setup, 2);
            hi = 0;
            while (lcd_en && hi < 100) begin
                hi++;
                @(negedge clk);
            end
            chk("vec_en_high", hi, 3);
            chk("vec_data_held", 32'(lcd_data), 32'(vec[j].data));
        end

        // Clients 0 and 2 contend with 3-byte locked transactions.
        p0 = 0;
        p2 = 0;
        nack = 0;
        cyc = 0;
        set_client(0, 1'b1, 1'b1, b0[0], 1'b0);
        set_client(2, 1'b1, 1'b1, b2[0], 1'b0);
        while (nack < 6 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (ack != 3'b000) begin
                exp_ack = '0;
                exp_ack[ord_c[nack]] = 1'b1;
                chk("lock_ack_order", 32'(ack), 32'(exp_ack));
                chk("lock_grant", 32'(grant), 32'(ord_g[nack]));
                chk("lock_data", 32'(lcd_data), 32'(ord_d[nack]));
                if (ack[0]) begin
                    p0++;
                    if (p0 < 3) set_client(0, 1'b1, 1'b1, b0[p0], p0 == 2);
                    else set_client(0, 1'b0, 1'b0, 8'h00, 1'b0);
                end
                if (ack[2]) begin
                    p2++;
                    if (p2 < 3) set_client(2, 1'b1, 1'b1, b2[p2], p2 == 2);
                    else set_client(2, 1'b0, 1'b0, 8'h00, 1'b0);
                end
                nack++;
            end
        end
        chk("lock_ack_count", nack, 6);
        req = '0;
        repeat (12) @(negedge clk);

        // Client 0 takes the lock then goes quiet; client 1 waits for the timeout.
        set_client(0, 1'b1, 1'b1, 8'h61, 1'b0);
        n = 0;
        while (ack == 3'b000 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("to_owner_ack", 32'(ack), 32'b001);
        chk("to_owner_grant", 32'(grant), 32'b001);
        set_client(0, 1'b0, 1'b0, 8'h00, 1'b0);
        set_client(1, 1'b1, 1'b1, 8'h62, 1'b1);
        n = 0;
        g0 = -1;
        do begin
            @(negedge clk);
            n++;
            if (grant == 3'b000 && g0 < 0) g0 = n;
        end while (ack == 3'b000 && n < 300);
        chk("to_ack_delay", n, 60);
        chk("to_grant_release", g0, 59);
        chk("to_ack", 32'(ack), 32'b010);
        chk("to_grant_after", 32'(grant), 32'b000);
        chk("to_data", 32'(lcd_data), 32'h62);
        set_client(1, 1'b0, 1'b0, 8'h00, 1'b0);

        // Reset while client 1's byte is in its EN pulse.
        n = 0;
        while (!lcd_en && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("mid_in_pulse", 32'(lcd_en), 1);
        rst = 1'b1;
        set_client(0, 1'b1, 1'b1, 8'h55, 1'b1);
        @(negedge clk);
        chk("mid_rst_en", 32'(lcd_en), 0);
        chk("mid_rst_ready", 32'(ready), 0);
        chk("mid_rst_ack", 32'(ack), 0);
        chk("mid_rst_grant", 32'(grant), 0);
        chk("mid_rst_data", 32'(lcd_data), 0);
        rst = 1'b0;
        check_init();
        repeat (5) @(negedge clk);
        chk("post_no_ack", 32'(ack), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
